gpc_fetch: RTL and testbench

Parametrised instruction-fetch front end for the Gwen Processor Core. It owns the program counter, starts at a configurable reset vector, and issues one outstanding request at a time to instruction memory through a valid/ready request channel and a valid response channel. It hands each fetched instruction, tagged with its PC, to decode through a valid/ready handshake. It also accepts PC redirects from execute, stops fetching once an `ebreak` instruction has been consumed, and counts consumed instructions.

---
 rtl/gpc_fetch.sv | 103 ++++++++++
 tb/tb_gpc_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpc_fetch.sv
// Instruction-fetch front end: one outstanding imem request, registered instruction to decode.
// Best case 3 cycles per instruction; decode backpressure holds inst/inst_pc/pc and stalls fetch.
module gpc_fetch #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 'h80000000,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  inst_pc,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  pc,
  output logic             ebreak,
  output logic [CNT_W-1:0] icount
);

  localparam logic [31:0] EBREAK_INST = 32'h00100073;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN, HALT} state_t;

  state_t           state, state_nxt;
  logic [XLEN-1:0]  pc_nxt, inst_pc_nxt, redir_tgt;
  logic [31:0]      inst_nxt;
  logic [CNT_W-1:0] icount_nxt;

  assign redir_tgt      = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc;
  assign inst_valid     = (state == HOLD);
  assign ebreak         = (state == HALT);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    inst_nxt    = inst;
    inst_pc_nxt = inst_pc;
    icount_nxt  = icount;

    case (state)
      IDLE:  state_nxt = REQ;
      REQ:   if (imem_req_ready) state_nxt = WAIT;
      WAIT: begin
        if (imem_rsp_valid) begin
          inst_nxt    = imem_rsp_data;
          inst_pc_nxt = pc;
          state_nxt   = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          pc_nxt     = pc + XLEN'(4);
          icount_nxt = icount + CNT_W'(1);
          state_nxt  = (inst == EBREAK_INST) ? HALT : REQ;
        end
      end
      DRAIN: if (imem_rsp_valid) state_nxt = REQ;
      HALT:  state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides pc+4 and any capture; a completing decode handshake still counts.
    if (redirect_valid && state != HALT) begin
      pc_nxt = redir_tgt;
      case (state)
        REQ:  state_nxt = imem_req_ready ? DRAIN : REQ;
        WAIT: begin
          inst_nxt    = inst;
          inst_pc_nxt = inst_pc;
          state_nxt   = imem_rsp_valid ? REQ : DRAIN;
        end
        // A response landing alongside the redirect still retires the outstanding request.
        DRAIN:   state_nxt = imem_rsp_valid ? REQ : DRAIN;
        default: state_nxt = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_VEC;
      inst    <= '0;
      inst_pc <= '0;
      icount  <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      inst    <= inst_nxt;
      inst_pc <= inst_pc_nxt;
      icount  <= icount_nxt;
    end
  end

endmodule

// File: tb/tb_gpc_fetch.sv
// Randomized bench for gpc_fetch: memory/decode/execute stimulus with a transaction-level PC model and scoreboard.
module tb_gpc_fetch;

  localparam logic [31:0] RV   = 32'h80000000;
  localparam logic [31:0] EBRK = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc, pc;
  logic        ebreak;
  logic [31:0] icount;

  gpc_fetch #(.XLEN(32), .RESET_VEC(RV), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc), .ebreak(ebreak), .icount(icount)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
  endtask

  // Stimulus knobs
  bit          nop_mode, rr_rand, redir_wait, redir_done, force_ebrk, best_case;
  int          rdy_mode, lat_min, lat_max, redir_pct;
  logic [31:0] ebreak_addr;

  // Memory state
  bit          pending;
  int          wait_c, hold_cnt;
  logic [31:0] mem_addr;

  // Reference model: next PC decode should see, consumed count, halt flag
  logic [31:0] exp_q[$];
  logic [31:0] hs_pcs[$];
  int          mcount, cyc, last_hs_cyc;
  bit          halted, mon_en, held_prev;
  logic [31:0] prev_inst, prev_inst_pc, prev_pc, mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == ebreak_addr) return EBRK;
    if (nop_mode) return 32'h00000013;
    return a ^ 32'h5a5a0013;
  endfunction

  task automatic model_init();
    exp_q.delete();
    exp_q.push_back(RV);
    hs_pcs.delete();
    mcount = 0; halted = 0; held_prev = 0; last_hs_cyc = -1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("addr_is_pc", imem_addr, pc);
      chk("icount", icount, 32'(mcount));
      chk("ebreak", 32'(ebreak), 32'(halted));
      if (halted) begin
        chk("halt_no_req", 32'(imem_req_valid), 0);
        chk("halt_no_inst", 32'(inst_valid), 0);
      end else if (imem_req_valid) begin
        chk("req_addr", imem_addr, exp_q[0]);
      end
      if (held_prev && inst_valid) begin
        chk("hold_inst", inst, prev_inst);
        chk("hold_inst_pc", inst_pc, prev_inst_pc);
        chk("hold_pc", pc, prev_pc);
      end
      if (inst_valid && inst_ready) begin
        mon_e = exp_q.pop_front();
        chk("inst_pc", inst_pc, mon_e);
        chk("inst", inst, mem_word(mon_e));
        if (best_case && last_hs_cyc >= 0) chk("inst_gap", 32'(cyc - last_hs_cyc), 3);
        last_hs_cyc = cyc;
        hs_pcs.push_back(inst_pc);
        mcount++;
        exp_q.delete();
        if (redirect_valid) exp_q.push_back(redirect_pc & ~32'h3);
        else if (mem_word(mon_e) == EBRK) halted = 1;
        else exp_q.push_back(mon_e + 32'd4);
      end else if (redirect_valid && !halted) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc & ~32'h3);
      end
      held_prev    = inst_valid && !inst_ready && !redirect_valid;
      prev_inst    = inst;
      prev_inst_pc = inst_pc;
      prev_pc      = pc;
    end
  end

  task automatic step();
    bit          acc;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready && !rst;
    a   = imem_addr;
    @(posedge clk); #1;
    if (imem_rsp_valid) pending = 0;
    if (acc) begin
      chk("one_outstanding", 32'(pending), 0);
      pending  = 1;
      mem_addr = a;
      wait_c   = $urandom_range(lat_max, lat_min) - 1;
    end else if (pending && wait_c > 0) begin
      wait_c--;
    end
    imem_rsp_valid = pending && wait_c == 0;
    imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
    imem_req_ready = rr_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    hold_cnt = inst_valid ? hold_cnt + 1 : 0;
    case (rdy_mode)
      0:       inst_ready = 1'b1;
      1:       inst_ready = 1'($urandom_range(1, 0));
      default: inst_ready = hold_cnt > 5;
    endcase
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (redir_pct > 0 && $urandom_range(99, 0) < redir_pct) begin
      redirect_valid = 1'b1;
      redirect_pc    = RV | ($urandom & 32'hFF);
    end
    if (redir_wait && !redir_done && pending && !imem_rsp_valid && icount == 1) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80000103;
      redir_done     = 1;
    end
    if (force_ebrk && inst_valid && inst == EBRK) begin
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80000200;
    end
  endtask

  // Asserts rst mid-cycle, checks the asynchronous reset values, releases one cycle later.
  task automatic do_reset(input bit wait_edge);
    if (wait_edge) begin @(posedge clk); #1; end
    rst = 1'b1; mon_en = 0;
    redirect_valid = 0; inst_ready = 0; imem_req_ready = 0; imem_rsp_valid = 0;
    pending = 0; hold_cnt = 0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_pc", pc, RV);
    chk("rst_icount", icount, 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_ebreak", 32'(ebreak), 0);
    @(posedge clk); #1;
    model_init();
    rst = 1'b0; mon_en = 1;
  endtask

  task automatic knobs(input bit nop, input logic [31:0] ea, input int rmode,
                       input int lmin, input int lmax, input bit rr, input int rpct);
    nop_mode = nop; ebreak_addr = ea; rdy_mode = rmode;
    lat_min = lmin; lat_max = lmax; rr_rand = rr; redir_pct = rpct;
  endtask

  initial begin
    int guard;
    rst = 1'b1; cyc = 0; mon_en = 0;
    redirect_valid = 0; redirect_pc = '0; imem_rsp_valid = 0; imem_rsp_data = '0;
    imem_req_ready = 1; inst_ready = 1;
    pending = 0; hold_cnt = 0; wait_c = 0; mem_addr = '0;
    redir_wait = 0; redir_done = 0; force_ebrk = 0; best_case = 0;
    knobs(1, 32'h1, 0, 1, 1, 0, 0);
    #2;
    chk("init_req_valid", 32'(imem_req_valid), 0);
    chk("init_pc", pc, RV);
    chk("init_inst", inst, 0);
    chk("init_inst_pc", inst_pc, 0);
    chk("init_icount", icount, 0);
    chk("init_inst_valid", 32'(inst_valid), 0);
    chk("init_ebreak", 32'(ebreak), 0);
    model_init();
    #1 rst = 1'b0; mon_en = 1;

    // Best case: always ready, one-cycle response, nops
    best_case = 1;
    repeat (10) step();
    chk("best_icount", icount, 3);
    chk("best_hs_count", 32'(hs_pcs.size()), 3);
    if (hs_pcs.size() >= 3) begin
      chk("best_pc0", hs_pcs[0], 32'h80000000);
      chk("best_pc1", hs_pcs[1], 32'h80000004);
      chk("best_pc2", hs_pcs[2], 32'h80000008);
    end
    best_case = 0;

    // Decode backpressure: five stalled HOLD cycles per instruction
    do_reset(1);
    knobs(0, 32'h1, 2, 1, 1, 1, 0);
    repeat (40) step();
    chk("stall_progress", 32'(hs_pcs.size() >= 2), 1);

    // Redirect while WAIT: response dropped, refetch from aligned target
    do_reset(1);
    knobs(0, 32'h1, 0, 3, 3, 0, 0);
    redir_wait = 1; redir_done = 0;
    repeat (40) step();
    redir_wait = 0;
    chk("wait_redir_hs_count", 32'(hs_pcs.size() >= 2), 1);
    if (hs_pcs.size() >= 2) chk("wait_redir_pc", hs_pcs[1], 32'h80000100);

    // ebreak at 0x80000008, then redirects that must be ignored
    do_reset(1);
    knobs(1, 32'h80000008, 0, 1, 1, 0, 0);
    repeat (12) step();
    redir_pct = 50;
    repeat (10) step();
    redir_pct = 0;
    chk("halt_icount", icount, 3);
    chk("halt_ebreak", 32'(ebreak), 1);
    chk("halt_pc", pc, 32'h8000000C);

    // ebreak consumed together with a redirect: no halt
    do_reset(1);
    knobs(1, 32'h80000004, 0, 1, 1, 0, 0);
    force_ebrk = 1;
    repeat (20) step();
    force_ebrk = 0;
    chk("force_ebreak_low", 32'(ebreak), 0);
    chk("force_hs_count", 32'(hs_pcs.size() >= 3), 1);
    if (hs_pcs.size() >= 3) begin
      chk("force_pc1", hs_pcs[1], 32'h80000004);
      chk("force_pc2", hs_pcs[2], 32'h80000200);
    end

    // Asynchronous reset while WAIT
    do_reset(1);
    knobs(0, 32'h1, 0, 3, 3, 0, 0);
    guard = 0;
    do begin
      step();
      guard++;
    end while (!(pending && wait_c > 0 && icount >= 1) && guard < 40);
    chk("reach_wait", 32'(guard < 40), 1);
    do_reset(0);
    @(negedge clk);
    chk("post_rst_idle", 32'(imem_req_valid), 0);
    @(negedge clk);
    chk("post_rst_req", 32'(imem_req_valid), 1);
    chk("post_rst_addr", imem_addr, RV);

    // Random rounds
    for (int r = 0; r < 6; r++) begin
      do_reset(1);
      knobs(0, 32'h80000040, 1, 1, 3, 1, 8);
      repeat (300) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
